// File: rtl/sha_bram_fetch_if.sv
// rtl/sha_bram_fetch_if.sv - BRAM read handshake between the SHA fetch engine and the BRAM interface
interface sha_bram_fetch_if;
  logic        sha_start_read;
  logic [31:0] sha_bram_addr;
  logic [31:0] sha_bram_read_data;
  logic        bram_complete;

  modport master (
    output sha_start_read,
    output sha_bram_addr,
    input  sha_bram_read_data,
    input  bram_complete
  );

  modport slave (
    input  sha_start_read,
    input  sha_bram_addr,
    output sha_bram_read_data,
    output bram_complete
  );
endinterface

// File: rtl/sha_bram_fetch.sv
// rtl/sha_bram_fetch.sv - fetches up to 16 words from BRAM into a message buffer for the SHA core
module sha_bram_fetch #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    axi_clk,
  input  logic                    axi_rst,
  input  logic                    fetch_start,
  input  logic [31:0]             fetch_base_addr,
  input  logic [4:0]              fetch_len,
  sha_bram_fetch_if.master        bram,
  input  logic [3:0]              msg_rd_idx,
  output logic [31:0]             msg_rd_data,
  output logic                    fetch_busy,
  output logic                    fetch_done,
  output logic                    fetch_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_REL  = 3'd2;
  localparam logic [2:0] ST_FIN  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  logic [2:0]    state, next_state;
  logic [31:0]   addr_q;
  logic [3:0]    last_idx;
  logic [3:0]    word_idx;
  logic [TW-1:0] tmo_q;
  logic          start_read_q;
  logic          err_q;
  logic [31:0]   buf_q [16];
  logic          tmo_hit;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));

  // A completion edge always wins over a timeout landing on the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (fetch_start) next_state = ST_REQ;
      ST_REQ: begin
        if (bram.bram_complete)  next_state = ST_REL;
        else if (tmo_hit)        next_state = ST_ERR;
      end
      ST_REL: begin
        if (!bram.bram_complete) next_state = (word_idx == last_idx) ? ST_FIN : ST_REQ;
        else if (tmo_hit)        next_state = ST_ERR;
      end
      ST_FIN:  next_state = ST_IDLE;
      ST_ERR:  if (!bram.bram_complete) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      last_idx     <= '0;
      word_idx     <= '0;
      tmo_q        <= '0;
      start_read_q <= 1'b0;
      err_q        <= 1'b0;
      for (int i = 0; i < 16; i++) buf_q[i] <= '0;
    end else begin
      state        <= next_state;
      start_read_q <= (next_state == ST_REQ);

      if (next_state != state)
        tmo_q <= '0;
      else if (state == ST_REQ || state == ST_REL)
        tmo_q <= tmo_q + 1'b1;

      case (state)
        ST_IDLE: begin
          if (fetch_start) begin
            addr_q   <= fetch_base_addr;
            // Length 0 and anything above 16 both mean a full 16-word block.
            last_idx <= (fetch_len == 5'd0 || fetch_len[4]) ? 4'hF : (fetch_len[3:0] - 4'd1);
            word_idx <= '0;
            err_q    <= 1'b0;
          end
        end
        ST_REQ: begin
          if (bram.bram_complete) buf_q[word_idx] <= bram.sha_bram_read_data;
        end
        ST_REL: begin
          if (!bram.bram_complete && word_idx != last_idx) begin
            word_idx <= word_idx + 4'd1;
            addr_q   <= addr_q + 32'd4;
          end
        end
        default: ;
      endcase

      if (next_state == ST_ERR && state != ST_ERR) err_q <= 1'b1;
    end
  end

  assign bram.sha_start_read = start_read_q;
  assign bram.sha_bram_addr  = addr_q;
  assign fetch_busy  = (state == ST_REQ) || (state == ST_REL) || (state == ST_ERR);
  assign fetch_done  = (state == ST_FIN);
  assign fetch_err   = err_q;
  assign msg_rd_data = buf_q[msg_rd_idx];

endmodule

// File: tb/tb_sha_bram_fetch.sv
// tb/tb_sha_bram_fetch.sv - scoreboard bench for sha_bram_fetch with a BRAM responder
module tb_sha_bram_fetch;

  logic        axi_clk = 1'b0;
  logic        axi_rst;
  logic        fetch_start;
  logic [31:0] fetch_base_addr;
  logic [4:0]  fetch_len;
  logic [3:0]  msg_rd_idx;
  logic [31:0] msg_rd_data;
  logic        fetch_busy, fetch_done, fetch_err;

  always #5 axi_clk = ~axi_clk;

  sha_bram_fetch_if bif ();

  sha_bram_fetch #(.TIMEOUT_CYC(255)) dut (
    .axi_clk         (axi_clk),
    .axi_rst         (axi_rst),
    .fetch_start     (fetch_start),
    .fetch_base_addr (fetch_base_addr),
    .fetch_len       (fetch_len),
    .bram            (bif),
    .msg_rd_idx      (msg_rd_idx),
    .msg_rd_data     (msg_rd_data),
    .fetch_busy      (fetch_busy),
    .fetch_done      (fetch_done),
    .fetch_err       (fetch_err)
  );

  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  int          read_cnt = 0;
  bit          resp_en = 1'b1;
  logic [31:0] exp_addr [$];
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] word_at(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_buf(string name, int idx, logic [31:0] exp);
    msg_rd_idx = 4'(idx);
    #1;
    check(name, msg_rd_data, exp);
  endtask

  task automatic push_seq(logic [31:0] base, int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(base + 32'(4 * i));
  endtask

  task automatic start_fetch(logic [31:0] base, logic [4:0] len);
    @(negedge axi_clk);
    fetch_base_addr = base;
    fetch_len       = len;
    fetch_start     = 1'b1;
    @(negedge axi_clk);
    fetch_start     = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    int n = 0;
    while (!fetch_done && n < budget) begin
      @(negedge axi_clk);
      n++;
    end
    checks++;
    if (!fetch_done) begin
      errors++;
      $display("FAIL %s: fetch_done not seen within %0d cycles", name, budget);
    end
    repeat (3) @(negedge axi_clk);
  endtask

  // Monitor: every new read request pops the next expected address.
  initial begin
    logic prev_sr = 1'b0;
    forever begin
      @(negedge axi_clk);
      if (bif.sha_start_read && !prev_sr) begin
        read_cnt++;
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: got addr %h expected no read", bif.sha_bram_addr);
        end else begin
          check("read_addr", bif.sha_bram_addr, exp_addr.pop_front());
        end
      end
      if (fetch_done) done_cnt++;
      prev_sr = bif.sha_start_read;
    end
  end

  // BRAM responder: completes a request one cycle after it appears.
  initial begin
    forever begin
      @(posedge axi_clk);
      #1;
      if (axi_rst || !resp_en) begin
        bif.bram_complete = 1'b0;
      end else if (bif.sha_start_read && !bif.bram_complete) begin
        bif.bram_complete      = 1'b1;
        bif.sha_bram_read_data = word_at(bif.sha_bram_addr);
      end else if (!bif.sha_start_read && bif.bram_complete) begin
        bif.bram_complete = 1'b0;
      end
    end
  end

  initial begin
    int d0, r0, cnt;
    axi_rst                = 1'b1;
    fetch_start            = 1'b0;
    fetch_base_addr        = '0;
    fetch_len              = '0;
    msg_rd_idx             = '0;
    bif.bram_complete      = 1'b0;
    bif.sha_bram_read_data = '0;
    mem[32'h100] = 32'h11;
    mem[32'h104] = 32'h22;
    mem[32'h108] = 32'h33;
    mem[32'h10C] = 32'h44;

    #2;
    check("rst_start_read", 32'(bif.sha_start_read), 0);
    check("rst_addr", bif.sha_bram_addr, 0);
    check("rst_busy", 32'(fetch_busy), 0);
    check("rst_done", 32'(fetch_done), 0);
    check("rst_err", 32'(fetch_err), 0);
    check("rst_buf0", msg_rd_data, 0);
    repeat (3) @(negedge axi_clk);
    axi_rst = 1'b0;

    // Four words at 0x100, with a stray start while busy that must be ignored.
    push_seq(32'h100, 4);
    d0 = done_cnt;
    start_fetch(32'h100, 5'd4);
    check("t1_busy", 32'(fetch_busy), 1);
    start_fetch(32'h200, 5'd2);
    wait_done("t1_done", 100);
    check("t1_done_count", 32'(done_cnt - d0), 1);
    check("t1_queue_empty", 32'(exp_addr.size()), 0);
    check("t1_busy_after", 32'(fetch_busy), 0);
    check_buf("t1_buf0", 0, 32'h11);
    check_buf("t1_buf1", 1, 32'h22);
    check_buf("t1_buf2", 2, 32'h33);
    check_buf("t1_buf3", 3, 32'h44);

    // len=0 means 16 words.
    push_seq(32'h0, 16);
    d0 = done_cnt;
    start_fetch(32'h0, 5'd0);
    wait_done("t2_done", 200);
    check("t2_done_count", 32'(done_cnt - d0), 1);
    check("t2_queue_empty", 32'(exp_addr.size()), 0);
    check_buf("t2_buf15", 15, 32'h003C_C0DE);

    // len=31 clamps to 16 words.
    push_seq(32'h800, 16);
    d0 = done_cnt;
    start_fetch(32'h800, 5'd31);
    wait_done("t3_done", 200);
    check("t3_done_count", 32'(done_cnt - d0), 1);
    check("t3_queue_empty", 32'(exp_addr.size()), 0);
    check_buf("t3_buf15", 15, 32'h083C_C0DE);

    // No completion ever arrives: timeout after 255 request cycles.
    resp_en = 1'b0;
    push_seq(32'h500, 1);
    d0 = done_cnt;
    start_fetch(32'h500, 5'd1);
    cnt = 0;
    while (bif.sha_start_read && cnt < 400) begin
      cnt++;
      @(negedge axi_clk);
    end
    check("t4_req_cycles", 32'(cnt), 255);
    check("t4_err", 32'(fetch_err), 1);
    check("t4_busy_in_err", 32'(fetch_busy), 1);
    @(negedge axi_clk);
    check("t4_idle_busy", 32'(fetch_busy), 0);
    repeat (3) @(negedge axi_clk);
    check("t4_err_sticky", 32'(fetch_err), 1);
    check("t4_no_done", 32'(done_cnt - d0), 0);
    check("t4_queue_empty", 32'(exp_addr.size()), 0);
    check_buf("t4_buf0_kept", 0, 32'h0800_C0DE);
    resp_en = 1'b1;

    // Reset in the middle of an 8-word fetch.
    push_seq(32'h300, 8);
    d0 = done_cnt;
    r0 = read_cnt;
    start_fetch(32'h300, 5'd8);
    check("t5_err_cleared", 32'(fetch_err), 0);
    cnt = 0;
    while (read_cnt - r0 < 3 && cnt < 100) begin
      @(negedge axi_clk);
      cnt++;
    end
    check("t5_reached_word3", 32'(read_cnt - r0 >= 3), 1);
    axi_rst = 1'b1;
    msg_rd_idx = 4'd0;
    #1;
    check("t5_rst_start_read", 32'(bif.sha_start_read), 0);
    check("t5_rst_addr", bif.sha_bram_addr, 0);
    check("t5_rst_busy", 32'(fetch_busy), 0);
    check("t5_rst_done", 32'(fetch_done), 0);
    check("t5_rst_err", 32'(fetch_err), 0);
    check("t5_rst_buf0", msg_rd_data, 0);
    exp_addr.delete();
    repeat (2) @(negedge axi_clk);
    axi_rst = 1'b0;
    check("t5_no_done", 32'(done_cnt - d0), 0);
    push_seq(32'h40, 1);
    d0 = done_cnt;
    start_fetch(32'h40, 5'd1);
    wait_done("t5_post_done", 50);
    check("t5_post_done_count", 32'(done_cnt - d0), 1);
    check("t5_queue_empty", 32'(exp_addr.size()), 0);
    check_buf("t5_post_buf0", 0, 32'h0040_C0DE);

    // Address wraps past the top of the 32-bit space.
    push_seq(32'hFFFF_FFFC, 2);
    d0 = done_cnt;
    start_fetch(32'hFFFF_FFFC, 5'd2);
    wait_done("t6_done", 50);
    check("t6_done_count", 32'(done_cnt - d0), 1);
    check("t6_queue_empty", 32'(exp_addr.size()), 0);
    check_buf("t6_buf0", 0, 32'hFFFC_C0DE);
    check_buf("t6_buf1", 1, 32'h0000_C0DE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha_bram_fetch.md
SHA_BRAM_FETCH -- requirements
Module: sha_bram_fetch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, the maximum cycles spent waiting on any single bram_complete edge before aborting.
REQ-002 SHALL have port axi_clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port axi_rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port fetch_start  input  1  one-cycle request to fetch a message block.
REQ-005 SHALL have port fetch_base_addr  input  32  byte address of the first word, sampled with fetch_start.
REQ-006 SHALL have port fetch_len  input  5  word count 1..16, sampled with fetch_start; 0 means 16, 17..31 are clamped to 16.
REQ-007 SHALL have port sha_start_read  output  1  read request to the BRAM interface.
REQ-008 SHALL have port sha_bram_addr  output  32  read address to the BRAM interface.
REQ-009 SHALL have port sha_bram_read_data  input  32  read data from the BRAM interface.
REQ-010 SHALL have port bram_complete  input  1  transaction-complete level from the BRAM interface.
REQ-011 SHALL have port msg_rd_idx  input  4  buffer word select.
REQ-012 SHALL have port msg_rd_data  output  32  buffer word at msg_rd_idx, combinational.
REQ-013 SHALL have ports fetch_busy, fetch_done, fetch_err  output  1 each  status.

Function
REQ-014 SHALL implement states IDLE, REQ, REL, FIN, ERR.
REQ-015 IDLE: on fetch_start=1, latch base address into the address register, latch the effective length, clear word index, clear fetch_err, go to REQ.
REQ-016 REQ: drive sha_start_read=1 and sha_bram_addr=the address register. When bram_complete=1 is sampled, write sha_bram_read_data to buf[word_idx], go to REL.
REQ-017 REL: drive sha_start_read=0. When bram_complete=0 is sampled, take one of two paths.
- If word_idx equals length-1, go to FIN.
- Otherwise increment word_idx, add 4 to the address register (modulo 2^32), and go to REQ.
REQ-018 FIN: assert fetch_done for exactly one cycle, then go to IDLE.
REQ-019 fetch_busy SHALL be 1 in REQ, REL and ERR, and 0 in IDLE and FIN.
REQ-020 A fetch_start that arrives outside IDLE SHALL be ignored, with no queuing.
REQ-021 The timeout counter SHALL clear on every state entry and increment each cycle spent in REQ or REL. On reaching TIMEOUT_CYC:
- drive sha_start_read=0;
- set fetch_err=1, sticky until the next accepted fetch_start;
- go to ERR.
REQ-022 ERR: stay until bram_complete=0 is sampled, then go to IDLE with no fetch_done pulse.
REQ-023 On abort, buffer words already written SHALL keep their values and unwritten words SHALL keep their previous contents.
REQ-024 In REQ, an address register of 32'hFFFF_FFFC followed by a further word SHALL wrap to 32'h0000_0000.
REQ-025 sha_start_read SHALL be registered, glitch-free, and 0 in every state other than REQ.
REQ-026 The buffer SHALL be 16x32 registers. msg_rd_data SHALL reflect a write on the cycle after the capture edge.

Reset
REQ-027 axi_rst=1 SHALL immediately set the following, regardless of clock:
- state IDLE;
- sha_start_read=0 and sha_bram_addr=0;
- fetch_busy=0, fetch_done=0 and fetch_err=0;
- word index, timeout counter and buffer contents all 0.
REQ-028 Reset asserted mid-fetch SHALL abandon the transaction with no done or error pulse. After release, the block SHALL accept fetch_start normally.

Verification
REQ-029 Set base=0x100 and len=4 against a BRAM responder holding 0x11,0x22,0x33,0x44. Required response:
- reads issued at 0x100, 0x104, 0x108, 0x10C;
- buf[0..3]=0x11..0x44;
- exactly one fetch_done pulse.
REQ-030 Set len=0 with base=0x0. Required response: 16 reads at 0x0..0x3C, one fetch_done pulse, msg_rd_idx=15 returns word 15.
REQ-031 Hold bram_complete at 0 forever after fetch_start. Required response: sha_start_read drops after 255 cycles, fetch_err=1, no fetch_done, and the block returns to IDLE.
REQ-032 Pulse fetch_start again while busy with base=0x200. Required response: ignored, original address sequence unchanged.
REQ-033 Assert axi_rst after the second word of a len=8 fetch. Required response: all outputs 0 within the same cycle. A subsequent len=1 fetch at 0x40 completes normally.
REQ-034 Set base=0xFFFF_FFFC and len=2. Required response: reads at 0xFFFF_FFFC, then 0x0000_0000.
